fv_bank_rd_requester: RTL and testbench
=======================================

Name: fv_bank_rd_requester

Overview:
- Initiator side of the feature-vector bank read interface.
- Accepts a stream of node IDs from the Edge PE side and maps each to a bank and a line address.
- Issues one single-cycle read request per cycle to the addressed FV bank, then collects the fixed-latency bank responses.
- Returns the feature vectors to the Edge PE in issue order through a credit-protected output FIFO; a start/done FSM frames each batch of edges.

Parameters:
- NUM_BANKS, 4, number of FV banks (power of 2); BANK_W = log2(NUM_BANKS).
- ADDR_W, 8, per-bank line-address width.
- DATA_W, 128, feature-vector width per bank line.
- TAG_W, 8, opaque edge tag carried alongside each request.
- RD_LAT, 1, cycles from bank request to bank response (1..4).
- OUT_DEPTH, 8, output FIFO entries (power of 2, ≥ RD_LAT+1).
- CNT_W, 16, batch edge-count width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  pulse in IDLE: latch num_edges and begin a batch.
- num_edges  in  CNT_W  edges in the batch; 0 means finish immediately.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse when the batch completes.
- in_valid  in  1  edge request valid.
- in_ready  out  1  requester can issue this cycle.
- in_node_id  in  BANK_W+ADDR_W  bank = [BANK_W-1:0], addr = upper bits.
- in_tag  in  TAG_W  edge tag.
- bank_req_valid  out  NUM_BANKS  one-hot read strobe.
- bank_req_addr  out  NUM_BANKS*ADDR_W  per-bank address; zero when that bank is not strobed.
- bank_rsp_valid  in  NUM_BANKS  response strobe, RD_LAT cycles after the request.
- bank_rsp_data  in  NUM_BANKS*DATA_W  response data.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  Edge PE accepts the head.
- out_data  out  DATA_W  feature vector.
- out_tag  out  TAG_W  tag of that vector.

Behaviour:
- Reset:
  - All outputs 0; FSM goes to IDLE.
  - FIFO and in-flight pipeline are cleared.
  - Counters are zeroed.
  - Reset mid-batch discards all in-flight responses. Responses arriving 1..RD_LAT cycles after reset deassertion are ignored because the in-flight pipeline is empty.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: start=1 and num_edges=0 → done pulse next cycle, stay IDLE. start=1 and num_edges>0 → RUN, with issue_left=num_edges and ret_left=num_edges.
  - RUN: issue while issue_left>0. When the last issue fires → DRAIN.
  - DRAIN: wait until ret_left reaches 0 → IDLE, with done=1 for one cycle on that transition.
  - start outside IDLE is ignored.
- Issue:
  - in_ready = (state==RUN) && (fifo_count + inflight_count < OUT_DEPTH).
  - A fire is in_valid && in_ready. Same cycle, combinationally: bank_req_valid[bank]=1, bank_req_addr[bank]=addr. issue_left decrements.
  - in_valid while not RUN is held off (in_ready=0); no request is issued.
- In-flight tracking:
  - An RD_LAT-deep shift pipeline of {valid, bank, tag}.
  - inflight_count is the number of valid stages (0..RD_LAT).
- Response capture:
  - When the pipeline tail is valid, data is taken from bank_rsp_data[tail.bank] and pushed into the FIFO with tail.tag.
  - If bank_rsp_valid[tail.bank]=0 at that cycle, the data is still pushed and sticky err_flag is set (debug only; not a port unless the optional feature is enabled).
  - bank_rsp_valid on a bank with no matching tail is ignored.
- Output FIFO:
  - out_valid = !empty, with first-word-fall-through.
  - A pop on out_valid && out_ready decrements ret_left.
  - Simultaneous push and pop keeps the count unchanged.
  - Credit gating guarantees the FIFO never overflows. A push with the FIFO full is an assertion failure.
- Ordering: output order equals issue order, independent of bank.
- Latency: first out_valid comes RD_LAT+1 cycles after the fire, registered at the FIFO write.
- Counters wrap is impossible: issue_left and ret_left saturate at 0.

Optional Feature:
- FV_REQ_PERF_CNT_EN defined: adds outputs stall_cycles (32 bits) and bank_hits (NUM_BANKS*16 bits).
  - stall_cycles counts RUN cycles with in_valid=1 and in_ready=0.
  - bank_hits counts fires per bank and saturates at 0xFFFF.
  - Both clear on reset and on start accepted in IDLE.
- Undefined: these ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Basic: RD_LAT=1, start with num_edges=4; node_ids 0x00,0x01,0x02,0x03, tags 1..4, out_ready=1 → one-hot strobes on banks 0..3 at addr 0; out_tag sequence 1,2,3,4; done exactly 1 cycle after the 4th pop.
- Same bank burst: 8 edges all with bank=2, addr 0..7 → bank_req_valid=4'b0100 for 8 consecutive cycles; output order preserved.
- Backpressure: OUT_DEPTH=8, out_ready=0, 12 edges → in_ready drops once fifo_count+inflight=8; exactly 8 issues occur; releasing out_ready completes all 12 and done pulses.
- num_edges=0 → done pulses the cycle after start; no bank_req_valid.
- Reset at the 3rd issue of a 6-edge batch → all outputs 0 next cycle; stale bank_rsp_valid ignored; a new batch of 2 completes correctly.
- With FV_REQ_PERF_CNT_EN: the backpressure run gives stall_cycles equal to the stalled cycles counted by the bench; bank_hits[bank0]=12 when all node_ids map to bank 0.

Source files
------------

// File: rtl/fv_bank_rd_requester.sv
// Feature-vector bank read requester: issues one bank read per edge, returns vectors in issue order.
// Optional build macro FV_REQ_PERF_CNT_EN adds stall/bank-hit counters and exposes err_flag.
module fv_bank_rd_requester #(
  parameter int NUM_BANKS = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 128,
  parameter int TAG_W     = 8,
  parameter int RD_LAT    = 1,
  parameter int OUT_DEPTH = 8,
  parameter int CNT_W     = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [CNT_W-1:0]                   num_edges,
  output logic                               busy,
  output logic                               done,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [$clog2(NUM_BANKS)+ADDR_W-1:0] in_node_id,
  input  logic [TAG_W-1:0]                   in_tag,
  output logic [NUM_BANKS-1:0]               bank_req_valid,
  output logic [NUM_BANKS*ADDR_W-1:0]        bank_req_addr,
  input  logic [NUM_BANKS-1:0]               bank_rsp_valid,
  input  logic [NUM_BANKS*DATA_W-1:0]        bank_rsp_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_W-1:0]                  out_data,
  output logic [TAG_W-1:0]                   out_tag
`ifdef FV_REQ_PERF_CNT_EN
  ,
  output logic [31:0]                        stall_cycles,
  output logic [NUM_BANKS*16-1:0]            bank_hits,
  output logic                               err_flag
`endif
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int NODE_W = BANK_W + ADDR_W;
  localparam int PTR_W  = $clog2(OUT_DEPTH);
  localparam int FCNT_W = PTR_W + 1;
  localparam int OCC_W  = PTR_W + 2;
  localparam int ENT_W  = DATA_W + TAG_W;

  // IDLE: wait for start | RUN: issuing edges | DRAIN: collecting remaining responses
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_done, w_done_nxt;
  logic [CNT_W-1:0]   r_issue_left, r_ret_left;

  logic               r_pv [RD_LAT];
  logic [BANK_W-1:0]  r_pb [RD_LAT];
  logic [TAG_W-1:0]   r_pt [RD_LAT];

  logic [ENT_W-1:0]   r_mem [OUT_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [FCNT_W-1:0]  r_fcnt;
  logic               r_err_flag;

  logic [BANK_W-1:0]  w_bank, w_tail_bank;
  logic [ADDR_W-1:0]  w_addr;
  logic               w_fire, w_push, w_pop, w_rsp_ok, w_start_acc;
  logic [OCC_W-1:0]   w_inflight, w_occ;
  logic [DATA_W-1:0]  w_rsp_data;
  logic [ENT_W-1:0]   w_head;

  assign w_bank      = in_node_id[BANK_W-1:0];
  assign w_addr      = in_node_id[NODE_W-1:BANK_W];
  assign w_start_acc = (r_state == S_IDLE) && start;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++)
      if (r_pv[i]) w_inflight = w_inflight + OCC_W'(1);
  end

  // Credit check covers both queued and in-flight entries so a push never finds the FIFO full.
  assign w_occ    = OCC_W'(r_fcnt) + w_inflight;
  assign in_ready = (r_state == S_RUN) && (r_issue_left != '0) && (w_occ < OCC_W'(OUT_DEPTH));
  assign w_fire   = in_valid && in_ready;

  always_comb begin
    bank_req_valid = '0;
    bank_req_addr  = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (w_fire && (w_bank == BANK_W'(b))) begin
        bank_req_valid[b]                  = 1'b1;
        bank_req_addr[b*ADDR_W +: ADDR_W]  = w_addr;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (num_edges == '0) w_done_nxt  = 1'b1;
          else                 w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_fire && (r_issue_left == CNT_W'(1))) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if ((r_ret_left == '0) || (w_pop && (r_ret_left == CNT_W'(1)))) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_issue_left <= '0;
      r_ret_left   <= '0;
    end else if (w_start_acc) begin
      r_issue_left <= num_edges;
      r_ret_left   <= num_edges;
    end else begin
      if (w_fire && (r_issue_left != '0)) r_issue_left <= r_issue_left - CNT_W'(1);
      if (w_pop && (r_ret_left != '0))    r_ret_left   <= r_ret_left - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_pv[i] <= 1'b0;
        r_pb[i] <= '0;
        r_pt[i] <= '0;
      end
    end else begin
      r_pv[0] <= w_fire;
      r_pb[0] <= w_bank;
      r_pt[0] <= in_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pb[i] <= r_pb[i-1];
        r_pt[i] <= r_pt[i-1];
      end
    end
  end

  assign w_push      = r_pv[RD_LAT-1];
  assign w_tail_bank = r_pb[RD_LAT-1];

  always_comb begin
    w_rsp_data = '0;
    w_rsp_ok   = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (w_tail_bank == BANK_W'(b)) begin
        w_rsp_data = bank_rsp_data[b*DATA_W +: DATA_W];
        w_rsp_ok   = bank_rsp_valid[b];
      end
    end
  end

  assign out_valid = (r_fcnt != '0);
  assign w_pop     = out_valid && out_ready;
  assign w_head    = r_mem[r_rd_ptr];
  assign out_data  = out_valid ? w_head[ENT_W-1:TAG_W] : '0;
  assign out_tag   = out_valid ? w_head[TAG_W-1:0]     : '0;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_rsp_data, r_pt[RD_LAT-1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fcnt     <= '0;
      r_err_flag <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + FCNT_W'(1);
        2'b01:   r_fcnt <= r_fcnt - FCNT_W'(1);
        default: r_fcnt <= r_fcnt;
      endcase
      // A missing response strobe still pushes data so ordering is preserved; only flag it.
      if (w_push && !w_rsp_ok) r_err_flag <= 1'b1;
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;

  assert property (@(posedge clk) disable iff (reset) !(w_push && (r_fcnt == FCNT_W'(OUT_DEPTH))));

`ifdef FV_REQ_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [15:0] r_bank_hits [NUM_BANKS];

  always_ff @(posedge clk) begin
    if (reset || w_start_acc) begin
      r_stall_cycles <= '0;
      for (int b = 0; b < NUM_BANKS; b++) r_bank_hits[b] <= '0;
    end else begin
      if ((r_state == S_RUN) && in_valid && !in_ready) r_stall_cycles <= r_stall_cycles + 32'd1;
      for (int b = 0; b < NUM_BANKS; b++)
        if (w_fire && (w_bank == BANK_W'(b)) && (r_bank_hits[b] != 16'hFFFF))
          r_bank_hits[b] <= r_bank_hits[b] + 16'd1;
    end
  end

  always_comb begin
    bank_hits = '0;
    for (int b = 0; b < NUM_BANKS; b++) bank_hits[b*16 +: 16] = r_bank_hits[b];
  end

  assign stall_cycles = r_stall_cycles;
  assign err_flag     = r_err_flag;
`else
  logic w_unused;
  assign w_unused = r_err_flag;
`endif

endmodule

// File: tb/tb_fv_bank_rd_requester.sv
// Randomized self-checking bench for fv_bank_rd_requester against an issue-order scoreboard.
module tb_fv_bank_rd_requester;
  localparam int NB = 4, AW = 8, DW = 128, TW = 8, LAT = 1, DEPTH = 8, CW = 16, NW = 10;

  logic clk = 1'b0;
  logic reset, start, busy, done, in_valid, in_ready, out_valid, out_ready;
  logic [CW-1:0]    num_edges;
  logic [NW-1:0]    in_node_id;
  logic [TW-1:0]    in_tag, out_tag;
  logic [NB-1:0]    bank_req_valid, bank_rsp_valid;
  logic [NB*AW-1:0] bank_req_addr;
  logic [NB*DW-1:0] bank_rsp_data;
  logic [DW-1:0]    out_data;
`ifdef FV_REQ_PERF_CNT_EN
  logic [31:0]      stall_cycles;
  logic [NB*16-1:0] bank_hits;
  logic             err_flag;
`endif

  always #5 clk = ~clk;

  fv_bank_rd_requester #(.NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(DW), .TAG_W(TW),
                         .RD_LAT(LAT), .OUT_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .num_edges(num_edges), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_node_id(in_node_id), .in_tag(in_tag),
    .bank_req_valid(bank_req_valid), .bank_req_addr(bank_req_addr),
    .bank_rsp_valid(bank_rsp_valid), .bank_rsp_data(bank_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
`ifdef FV_REQ_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .bank_hits(bank_hits), .err_flag(err_flag)
`endif
  );

  function automatic logic [127:0] fv(input int b, input logic [7:0] a);
    logic [15:0] h;
    h = 16'(b * 7 + int'(a) * 13 + 16'h1234);
    return {4{8'(b), a, h}};
  endfunction

  // Bank memories: answer each strobe LAT cycles later, drive noise on idle banks.
  logic [NB-1:0]    pv [LAT];
  logic [NB*AW-1:0] pa [LAT];
  logic [NB-1:0]    noise_v;
  logic [NB*DW-1:0] noise_d;

  always @(posedge clk) begin
    pv[0] <= bank_req_valid;
    pa[0] <= bank_req_addr;
    for (int i = 1; i < LAT; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
    noise_v <= NB'($urandom);
    for (int b = 0; b < NB; b++) noise_d[b*DW +: DW] <= {$urandom, $urandom, $urandom, $urandom};
  end

  always_comb begin
    bank_rsp_valid = '0;
    bank_rsp_data  = '0;
    for (int b = 0; b < NB; b++) begin
      bank_rsp_valid[b] = pv[LAT-1][b] | noise_v[b];
      bank_rsp_data[b*DW +: DW] = pv[LAT-1][b] ? fv(b, pa[LAT-1][b*AW +: AW]) : noise_d[b*DW +: DW];
    end
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [127:0] d;
    logic [7:0]   tag;
    int           t;
  } exp_t;

  exp_t exp_q[$];
  int   e_node [64];
  logic [7:0] e_tag [64];

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ready"}, in_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_oval"}, out_valid, 0);
    check({tag, "_odata"}, out_data, 0);
    check({tag, "_otag"}, out_tag, 0);
    check({tag, "_rqv"}, bank_req_valid, 0);
    check({tag, "_rqa"}, bank_req_addr, 0);
  endtask

  // omode: 0 out_ready high, 1 random, 2 low until cycle 'hold'. rst_at>0 resets on that issue.
  task automatic run_batch(input int n, input bit vrand, input int omode, input int hold, input int rst_at);
    int issued = 0, popped = 0, done_due = -1, stall = 0, dut_issues = 0, b;
    int hits [NB];
    bit run, active, run_now, exp_ready, exp_ov, fire, finished = 0;
    logic [NB-1:0]    exp_rv;
    logic [NB*AW-1:0] exp_ra;
    logic [AW-1:0]    a;
    exp_t e;
    exp_q.delete();
    for (int i = 0; i < NB; i++) hits[i] = 0;
    start = 1'b1; num_edges = CW'(n); in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("start_ready", in_ready, 0);
    check("start_busy", busy, 0);
    @(posedge clk); #1;
    start = 1'b0;
    run = (n > 0); active = (n > 0);
    if (n == 0) done_due = 0;
    for (int t = 0; t < 600 && !finished; t++) begin
      run_now   = run;
      exp_ready = run && (issued < n) && ((issued - popped) < DEPTH);
      exp_ov    = (exp_q.size() > 0) && (exp_q[0].t <= t);
      in_valid  = run ? (vrand ? ($urandom_range(0, 3) != 0) : 1'b1) : 1'($urandom_range(0, 1));
      in_node_id = (in_valid && run) ? NW'(e_node[issued]) : NW'($urandom);
      in_tag     = (in_valid && run) ? e_tag[issued] : TW'($urandom);
      case (omode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (t >= hold);
      endcase
      fire = in_valid && exp_ready;
      if (rst_at > 0 && fire && issued == rst_at - 1) reset = 1'b1;
      @(negedge clk);
      check("in_ready", in_ready, exp_ready);
      check("busy", busy, active);
      check("done", done, done_due == t);
      if (done_due == t) finished = 1;
      if (fire) begin
        b = e_node[issued] % NB;
        a = AW'(e_node[issued] / NB);
        exp_rv = '0; exp_rv[b] = 1'b1;
        exp_ra = '0; exp_ra[b*AW +: AW] = a;
        check("req_valid", bank_req_valid, exp_rv);
        check("req_addr", bank_req_addr, exp_ra);
        e.d = fv(b, a); e.tag = e_tag[issued]; e.t = t + LAT + 1;
        exp_q.push_back(e);
        issued++; hits[b]++;
        if (issued == n) run = 0;
      end else begin
        check("req_idle", bank_req_valid, 0);
      end
      if (omode == 2 && t < hold && bank_req_valid != '0) dut_issues++;
      if (run_now && in_valid && !exp_ready) stall++;
      check("out_valid", out_valid, exp_ov);
      if (exp_ov && out_ready) begin
        check("out_tag", out_tag, exp_q[0].tag);
        check("out_data", out_data, exp_q[0].d);
        void'(exp_q.pop_front());
        popped++;
        if (popped == n) begin
          done_due = t + 1;
          active = 0;
        end
      end
      if (omode == 2 && t == hold - 1) check("bp_issues", dut_issues, DEPTH);
      if (reset) begin
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_zero_outputs("post_rst");
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("stale_oval", out_valid, 0);
        end
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    if (!finished) check("batch_timeout", 0, 1);
`ifdef FV_REQ_PERF_CNT_EN
    check("stall_cycles", stall_cycles, stall);
    for (int i = 0; i < NB; i++) check("bank_hits", bank_hits[i*16 +: 16], hits[i]);
`endif
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; num_edges = '0; in_valid = 1'b0;
    in_node_id = '0; in_tag = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    in_valid = 1'b1; in_node_id = NW'($urandom);
    @(negedge clk);
    check("idle_ready", in_ready, 0);
    check("idle_req", bank_req_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;

    for (int i = 0; i < 4; i++) begin e_node[i] = i; e_tag[i] = 8'(i + 1); end
    run_batch(4, 0, 0, 0, 0);

    for (int i = 0; i < 8; i++) begin e_node[i] = (i << 2) | 2; e_tag[i] = 8'($urandom); end
    run_batch(8, 0, 0, 0, 0);

    for (int i = 0; i < 12; i++) begin e_node[i] = $urandom_range(0, 1023); e_tag[i] = 8'($urandom); end
    run_batch(12, 0, 2, 30, 0);

    run_batch(0, 0, 0, 0, 0);

    for (int i = 0; i < 6; i++) begin e_node[i] = $urandom_range(0, 1023); e_tag[i] = 8'($urandom); end
    run_batch(6, 0, 0, 0, 3);
    for (int i = 0; i < 2; i++) begin e_node[i] = $urandom_range(0, 1023); e_tag[i] = 8'($urandom); end
    run_batch(2, 0, 0, 0, 0);

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) begin e_node[i] = $urandom_range(0, 1023); e_tag[i] = 8'($urandom); end
      run_batch(n, 1, 1, 0, 0);
    end

    for (int i = 0; i < 12; i++) begin e_node[i] = $urandom_range(0, 255) * NB; e_tag[i] = 8'($urandom); end
    run_batch(12, 0, 2, 20, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
